// File: rtl/fifo2_nbit.sv
// rtl/fifo2_nbit.sv - two-entry N-bit FIFO with registered storage and 1-bit pointers
module fifo2_nbit #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    input  logic         rd_en,
    output logic [N-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2;

    logic [N-1:0] mem_q [DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_d;
    logic         push;
    logic         pop;

    assign full    = (occ_q == 2'd2);
    assign empty   = (occ_q == 2'd0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - streaming 1-to-2 demux with a 2-entry buffer and word counter per channel
module demux1to2_stream #(
    parameter int N     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [N-1:0]     out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             full0, full1;
    logic             empty0, empty1;
    logic             accept;
    logic             wr_en0, wr_en1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Ready depends only on the selected channel's occupancy, never on a same-cycle pop.
    assign in_ready   = in_sel ? ~full1 : ~full0;
    assign accept     = in_valid & in_ready;
    assign wr_en0     = accept & ~in_sel;
    assign wr_en1     = accept & in_sel;
    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

    fifo2_nbit #(.N(N)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en0),
        .wr_data (in_data),
        .rd_en   (out0_ready),
        .rd_data (out0_data),
        .full    (full0),
        .empty   (empty0)
    );

    fifo2_nbit #(.N(N)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en1),
        .wr_data (in_data),
        .rd_en   (out1_ready),
        .rd_data (out1_data),
        .full    (full1),
        .empty   (empty1)
    );

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (wr_en0) cnt0_d = cnt0_q + 1'b1;
        if (wr_en1) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
endmodule
